// File: rtl/data_mem_unit_pkg.sv
// Shared types and helpers for the data-memory responder.
// Holds the access-size encoding, the FSM states and the load-extension rule.
package data_mem_unit_pkg;

  typedef enum logic [2:0] {
    MEM_B  = 3'd0,
    MEM_H  = 3'd1,
    MEM_W  = 3'd2,
    MEM_BU = 3'd4,
    MEM_HU = 3'd5
  } mem_size_e;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE,
    FAULT
  } dmem_state_e;

  // Picks the addressed byte/half out of a word and sign- or zero-extends it.
  function automatic logic [31:0] load_extend(input logic [31:0] word,
                                              input logic [2:0]  size,
                                              input logic [1:0]  off);
    logic [31:0] shifted;
    logic [7:0]  b;
    logic [15:0] h;
    shifted = word >> {off, 3'b000};
    b = shifted[7:0];
    h = shifted[15:0];
    case (size)
      MEM_B:   return {{24{b[7]}}, b};
      MEM_BU:  return {24'h0, b};
      MEM_H:   return {{16{h[15]}}, h};
      MEM_HU:  return {16'h0, h};
      default: return word;
    endcase
  endfunction

endpackage

// File: rtl/data_mem_unit_if.sv
// Load/store request and response bundle between the core and the data memory.
interface data_mem_unit_if;
  logic        ctrl_mem_read;
  logic        ctrl_mem_write;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] wr_data;
  logic [31:0] rd_data;
  logic        mem_stall;
  logic        mem_done;
  logic        mem_fault;

  modport master (
    output ctrl_mem_read, ctrl_mem_write, funct3, addr, wr_data,
    input  rd_data, mem_stall, mem_done, mem_fault
  );

  modport slave (
    input  ctrl_mem_read, ctrl_mem_write, funct3, addr, wr_data,
    output rd_data, mem_stall, mem_done, mem_fault
  );
endinterface

// File: rtl/data_mem_unit_sram_bank.sv
// Single-port word SRAM with per-byte write enables and a registered read.
module dmem_sram_bank #(
  parameter int DEPTH_WORDS = 1024,
  parameter int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic [AW-1:0] idx,
  input  logic [3:0]    we,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (we[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
    end
    rdata <= mem[idx];
  end

endmodule

// File: rtl/data_mem_unit.sv
// Data-memory responder: validates load/store requests, stalls for LATENCY
// cycles, then commits the store or returns the extended load result.
module data_mem_unit
  import data_mem_unit_pkg::*;
#(
  parameter int          DEPTH_WORDS = 1024,
  parameter int          LATENCY     = 2,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic           clk,
  input  logic           rst_n,
  data_mem_unit_if.slave bus
);

  localparam int          AW   = $clog2(DEPTH_WORDS);
  localparam int          CW   = $clog2(LATENCY + 1);
  localparam logic [31:0] SPAN = 32'(DEPTH_WORDS * 4);

  dmem_state_e   state;
  logic [CW-1:0] counter;
  logic [AW-1:0] lat_idx;
  logic [1:0]    lat_off;
  logic [2:0]    lat_size;
  logic [31:0]   lat_wdata;
  logic          lat_write;
  logic [31:0]   rd_q;
  logic          done_q;
  logic          fault_q;

  logic          req;
  logic [31:0]   offset;
  logic          illegal;
  logic          misaligned;
  logic          out_of_range;
  logic [AW-1:0] bank_idx;
  logic [3:0]    be;
  logic [31:0]   bank_wdata;
  logic [3:0]    bank_we;
  logic [31:0]   bank_rdata;

  assign req    = bus.ctrl_mem_read | bus.ctrl_mem_write;
  assign offset = bus.addr - BASE_ADDR;

  // Wrap-around of the subtraction lands far above SPAN, so it faults too.
  always_comb begin
    illegal = bus.ctrl_mem_read & bus.ctrl_mem_write;
    if (bus.ctrl_mem_read && (bus.funct3 == 3'd3 || bus.funct3 == 3'd6 || bus.funct3 == 3'd7))
      illegal = 1'b1;
    if (bus.ctrl_mem_write && bus.funct3 > 3'd2)
      illegal = 1'b1;
    misaligned = ((bus.funct3 == MEM_H || bus.funct3 == MEM_HU) && bus.addr[0]) ||
                 (bus.funct3 == MEM_W && bus.addr[1:0] != 2'b00);
    out_of_range = offset >= SPAN;
  end

  // Reading at the incoming index while idle makes the word ready by the last BUSY cycle.
  assign bank_idx = (state == IDLE) ? offset[AW+1:2] : lat_idx;

  always_comb begin
    case (lat_size)
      MEM_B: begin
        be         = 4'b0001 << lat_off;
        bank_wdata = {4{lat_wdata[7:0]}};
      end
      MEM_H: begin
        be         = 4'b0011 << lat_off;
        bank_wdata = {2{lat_wdata[15:0]}};
      end
      default: begin
        be         = 4'b1111;
        bank_wdata = lat_wdata;
      end
    endcase
    bank_we = (state == BUSY && counter == '0 && lat_write) ? be : 4'b0000;
  end

  dmem_sram_bank #(.DEPTH_WORDS(DEPTH_WORDS), .AW(AW)) u_bank (
    .clk   (clk),
    .idx   (bank_idx),
    .we    (bank_we),
    .wdata (bank_wdata),
    .rdata (bank_rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      counter   <= '0;
      lat_idx   <= '0;
      lat_off   <= 2'b00;
      lat_size  <= 3'd0;
      lat_wdata <= 32'h0;
      lat_write <= 1'b0;
      rd_q      <= 32'h0;
      done_q    <= 1'b0;
      fault_q   <= 1'b0;
    end else begin
      done_q  <= 1'b0;
      fault_q <= 1'b0;
      case (state)
        IDLE: begin
          if (req) begin
            if (illegal || misaligned || out_of_range) begin
              fault_q <= 1'b1;
              state   <= FAULT;
            end else begin
              lat_idx   <= offset[AW+1:2];
              lat_off   <= bus.addr[1:0];
              lat_size  <= bus.funct3;
              lat_wdata <= bus.wr_data;
              lat_write <= bus.ctrl_mem_write;
              counter   <= CW'(LATENCY - 1);
              state     <= BUSY;
            end
          end
        end
        BUSY: begin
          if (counter == '0) begin
            if (!lat_write) rd_q <= load_extend(bank_rdata, lat_size, lat_off);
            done_q <= 1'b1;
            state  <= DONE;
          end else begin
            counter <= counter - 1'b1;
          end
        end
        DONE:    state <= IDLE;
        FAULT:   state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.rd_data   = rd_q;
  assign bus.mem_done  = done_q;
  assign bus.mem_fault = fault_q;
  assign bus.mem_stall = (state == IDLE && req) || state == BUSY;

endmodule

// File: tb/tb_data_mem_unit.sv
// Scoreboard bench for data_mem_unit: a byte-array reference model predicts
// every response, and a monitor compares them as the DUT presents them.
module tb_data_mem_unit;
  import data_mem_unit_pkg::*;

  localparam int DEPTH   = 1024;
  localparam int LAT     = 2;
  localparam int MEMSIZE = DEPTH * 4;

  typedef struct {
    bit          fault;
    logic [31:0] rd;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  data_mem_unit_if bus ();

  data_mem_unit #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT), .BASE_ADDR(32'h0)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  logic [7:0]  mdl [MEMSIZE];
  logic [31:0] last_rd;
  exp_t        sb [$];
  int          n_checks = 0;
  int          n_pass   = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  function automatic bit model_fault(input bit rd, input bit wr, input logic [2:0] f3, input logic [31:0] a);
    int n;
    if (rd && wr) return 1;
    if (rd && !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) return 1;
    if (wr && f3 > 3'd2) return 1;
    n = 1 << f3[1:0];
    if ((f3[1:0] == 2'd1 || f3[1:0] == 2'd2) && (a % n) != 0) return 1;
    if (a >= 32'(MEMSIZE)) return 1;
    return 0;
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a);
    int          n;
    logic [31:0] v;
    n = 1 << f3[1:0];
    v = 32'h0;
    for (int i = 0; i < n; i++) v = v | (32'(mdl[int'(a) + i]) << (8 * i));
    if (!f3[2] && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8 * n));
    return v;
  endfunction

  task automatic model_store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
    int n;
    n = 1 << f3[1:0];
    for (int i = 0; i < n; i++) mdl[int'(a) + i] = wd[8*i +: 8];
  endtask

  // Predicts the response, drives the request and holds it until the DUT lets the pipeline go.
  task automatic applyStimulus(input bit rd, input bit wr, input logic [2:0] f3,
                               input logic [31:0] a, input logic [31:0] wd, input bit scramble);
    exp_t e;
    int   stalls;
    bit   finished;
    e.fault = model_fault(rd, wr, f3, a);
    if (!e.fault && rd) last_rd = model_load(f3, a);
    if (!e.fault && wr) model_store(f3, a, wd);
    e.rd = last_rd;
    sb.push_back(e);
    bus.ctrl_mem_read  = rd;
    bus.ctrl_mem_write = wr;
    bus.funct3         = f3;
    bus.addr           = a;
    bus.wr_data        = wd;
    stalls   = 0;
    finished = 0;
    for (int c = 0; c < 20 && !finished; c++) begin
      #1;
      if (bus.mem_stall) stalls++;
      @(posedge clk);
      #1;
      if (scramble && c == 0) begin
        bus.addr    = $urandom_range(0, 255) & 32'hFC;
        bus.wr_data = $urandom;
      end
      if (bus.mem_done || bus.mem_fault) finished = 1;
    end
    checkOutput("completion_seen", 32'(finished), 32'd1);
    checkOutput("stall_cycles", stalls, e.fault ? 32'd1 : 32'(LAT + 1));
    bus.ctrl_mem_read  = 1'b0;
    bus.ctrl_mem_write = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // Monitor: every done/fault pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n && (bus.mem_done || bus.mem_fault)) begin
      if (sb.size() == 0) begin
        n_checks++;
        $display("[TB] FAIL unexpected_response: done=%b fault=%b with no request outstanding",
                 bus.mem_done, bus.mem_fault);
      end else begin
        exp_t e;
        e = sb.pop_front();
        checkOutput("mem_fault", 32'(bus.mem_fault), 32'(e.fault));
        checkOutput("mem_done", 32'(bus.mem_done), 32'(!e.fault));
        checkOutput("rd_data", bus.rd_data, e.rd);
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit          rd, wr;
    logic [2:0]  f3;
    logic [31:0] a;
    int          r;
    logic [2:0]  ld_sizes [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};

    last_rd            = 32'h0;
    rst_n              = 1'b0;
    bus.ctrl_mem_read  = 1'b0;
    bus.ctrl_mem_write = 1'b0;
    bus.funct3         = 3'd0;
    bus.addr           = 32'h0;
    bus.wr_data        = 32'h0;
    #13;
    checkOutput("reset_rd_data", bus.rd_data, 32'h0);
    checkOutput("reset_mem_done", 32'(bus.mem_done), 32'h0);
    checkOutput("reset_mem_fault", 32'(bus.mem_fault), 32'h0);
    checkOutput("reset_mem_stall", 32'(bus.mem_stall), 32'h0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int w = 0; w < 64; w++) applyStimulus(0, 1, MEM_W, 32'(w * 4), $urandom, 0);

    applyStimulus(0, 1, MEM_W, 32'h10, 32'hDEAD_BEEF, 0);
    applyStimulus(1, 0, MEM_W, 32'h10, 32'h0, 0);
    applyStimulus(0, 1, MEM_B, 32'h21, 32'h0000_0080, 0);
    applyStimulus(1, 0, MEM_B, 32'h21, 32'h0, 0);
    applyStimulus(1, 0, MEM_BU, 32'h21, 32'h0, 0);
    applyStimulus(1, 0, MEM_W, 32'h20, 32'h0, 0);
    applyStimulus(0, 1, MEM_H, 32'h32, 32'h1234_ABCD, 0);
    applyStimulus(1, 0, MEM_H, 32'h32, 32'h0, 0);
    applyStimulus(1, 0, MEM_HU, 32'h32, 32'h0, 0);
    applyStimulus(1, 0, MEM_W, 32'h30, 32'h0, 0);
    applyStimulus(1, 0, MEM_W, 32'h13, 32'h0, 0);
    applyStimulus(1, 1, MEM_W, 32'h10, 32'h1111_1111, 0);
    applyStimulus(1, 0, MEM_W, 32'(MEMSIZE), 32'h0, 0);
    applyStimulus(0, 1, MEM_W, 32'hFFFF_FFFC, 32'h2222_2222, 0);
    applyStimulus(1, 0, 3'd3, 32'h10, 32'h0, 0);
    applyStimulus(0, 1, MEM_BU, 32'h10, 32'h3333_3333, 0);
    applyStimulus(1, 0, MEM_W, 32'h10, 32'h0, 0);

    applyStimulus(0, 1, MEM_W, 32'h44, 32'hCAFE_F00D, 1);
    applyStimulus(1, 0, MEM_W, 32'h44, 32'h0, 1);

    // A store aborted by reset before its commit cycle must leave memory untouched.
    bus.ctrl_mem_write = 1'b1;
    bus.funct3         = MEM_W;
    bus.addr           = 32'h40;
    bus.wr_data        = 32'h0000_0055;
    @(posedge clk);
    #1;
    rst_n              = 1'b0;
    bus.ctrl_mem_write = 1'b0;
    last_rd            = 32'h0;
    #1;
    checkOutput("abort_rd_data", bus.rd_data, 32'h0);
    checkOutput("abort_mem_stall", 32'(bus.mem_stall), 32'h0);
    checkOutput("abort_mem_done", 32'(bus.mem_done), 32'h0);
    checkOutput("abort_mem_fault", 32'(bus.mem_fault), 32'h0);
    #4;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    applyStimulus(1, 0, MEM_W, 32'h40, 32'h0, 0);

    for (int i = 0; i < 120; i++) begin
      r  = $urandom_range(0, 9);
      rd = (r < 5) || (r == 9);
      wr = (r >= 5);
      if ($urandom_range(0, 7) == 0) f3 = 3'($urandom_range(0, 7));
      else if (rd) f3 = ld_sizes[$urandom_range(0, 4)];
      else f3 = 3'($urandom_range(0, 2));
      if ($urandom_range(0, 15) == 0) a = 32'h1000 + $urandom_range(0, 255);
      else a = $urandom_range(0, 255);
      if (!rd && !wr) rd = 1;
      applyStimulus(rd, wr, f3, a, $urandom, 0);
    end

    repeat (4) @(posedge clk);
    #1;
    checkOutput("scoreboard_drained", sb.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
